// File: rtl/stopwatch_ctrl_if.sv
// Stopwatch control bundle: raw buttons in, tick/clear/status out.
// The controller takes the slave side; whoever drives the buttons and
// consumes the pulses takes the master side.
interface stopwatch_ctrl_if;
  logic       btn_start_stop_raw;
  logic       btn_clear_raw;
  logic       tick_en;
  logic       counter_clr;
  logic       running;
  logic [1:0] state;

  modport master (
    output btn_start_stop_raw,
    output btn_clear_raw,
    input  tick_en,
    input  counter_clr,
    input  running,
    input  state
  );

  modport slave (
    input  btn_start_stop_raw,
    input  btn_clear_raw,
    output tick_en,
    output counter_clr,
    output running,
    output state
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch front-end control: button synchronisers and debouncers,
// IDLE/RUN/PAUSED state machine, and the tick prescaler that enables the
// lowest counter digit. Index 0 of the per-button vectors is start/stop,
// index 1 is clear.
module stopwatch_ctrl #(
  parameter int CLK_DIV   = 1000000,
  parameter int DIV_WIDTH = 20,
  parameter int DEBOUNCE  = 500000,
  parameter int DB_WIDTH  = 19
) (
  input  logic             clk,
  input  logic             rst_n,
  stopwatch_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_PAUSED = 2'b10
  } state_t;

  localparam logic [DB_WIDTH-1:0]  DB_LAST  = DB_WIDTH'(DEBOUNCE - 1);
  localparam logic [DIV_WIDTH-1:0] DIV_LAST = DIV_WIDTH'(CLK_DIV - 1);

  logic [1:0]          r_sync_s1;
  logic [1:0]          r_sync_s2;
  logic [1:0]          r_db_level;
  logic [1:0]          r_db_level_q;
  logic [DB_WIDTH-1:0] r_db_cnt [2];
  logic [1:0]          w_press;
  logic                w_ss_press;
  logic                w_clr_press;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_running;
  logic                r_counter_clr;
  logic                r_tick_en;
  logic [DIV_WIDTH-1:0] r_div_cnt;

  // Two-flop synchroniser for both raw buttons.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync_s1 <= '0;
      r_sync_s2 <= '0;
    end else begin
      r_sync_s1 <= {bus.btn_clear_raw, bus.btn_start_stop_raw};
      r_sync_s2 <= r_sync_s1;
    end
  end

  // Debounce: accept a new level only after it has differed for DEBOUNCE cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_db_level   <= '0;
      r_db_level_q <= '0;
      r_db_cnt[0]  <= '0;
      r_db_cnt[1]  <= '0;
    end else begin
      r_db_level_q <= r_db_level;
      for (int i = 0; i < 2; i++) begin
        if (r_sync_s2[i] == r_db_level[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DB_LAST) begin
          r_db_level[i] <= r_sync_s2[i];
          r_db_cnt[i]   <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // A press is the single cycle where the debounced level has just risen;
  // releases never generate an event.
  assign w_press     = r_db_level & ~r_db_level_q;
  assign w_ss_press  = w_press[0];
  assign w_clr_press = w_press[1];

  // Next-state logic: clear beats start/stop; the unused code falls back to IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_ss_press) w_state_nxt = ST_RUN;
      ST_RUN:    if (w_ss_press) w_state_nxt = ST_PAUSED;
      ST_PAUSED: if (w_ss_press) w_state_nxt = ST_RUN;
      default:   w_state_nxt = ST_IDLE;
    endcase
    if (w_clr_press) begin
      w_state_nxt = ST_IDLE;
    end
  end

  // State register plus the registered status and clear pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_running     <= 1'b0;
      r_counter_clr <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_running     <= (w_state_nxt == ST_RUN);
      r_counter_clr <= w_clr_press;
    end
  end

  // Prescaler runs on the current (pre-transition) state, so a RUN->PAUSED
  // edge can still emit a final tick, and PAUSED keeps the partial period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_cnt <= '0;
      r_tick_en <= 1'b0;
    end else if (w_clr_press) begin
      r_div_cnt <= '0;
      r_tick_en <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (r_div_cnt == DIV_LAST) begin
            r_div_cnt <= '0;
            r_tick_en <= 1'b1;
          end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
            r_tick_en <= 1'b0;
          end
        end
        ST_PAUSED: begin
          r_tick_en <= 1'b0;
        end
        default: begin
          r_div_cnt <= '0;
          r_tick_en <= 1'b0;
        end
      endcase
    end
  end

  assign bus.state       = r_state;
  assign bus.running     = r_running;
  assign bus.counter_clr = r_counter_clr;
  assign bus.tick_en     = r_tick_en;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with CLK_DIV=4, DEBOUNCE=3.
// Edge numbering in comments: E0 is the first rising edge that samples a
// newly driven button level; outputs are sampled 1 ns after each edge.
module tb_stopwatch_ctrl;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  stopwatch_ctrl_if sw_if ();

  stopwatch_ctrl #(
    .CLK_DIV   (4),
    .DIV_WIDTH (3),
    .DEBOUNCE  (3),
    .DB_WIDTH  (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sw_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [1:0] st, input logic run,
                         input logic tick, input logic clr);
    chk({tag, ".state"},       sw_if.state,                st);
    chk({tag, ".running"},     {1'b0, sw_if.running},      {1'b0, run});
    chk({tag, ".tick_en"},     {1'b0, sw_if.tick_en},      {1'b0, tick});
    chk({tag, ".counter_clr"}, {1'b0, sw_if.counter_clr},  {1'b0, clr});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic step_n(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    errors = 0;
    checks = 0;

    // 1. Reset held with both buttons high.
    rst_n = 1'b0;
    sw_if.btn_start_stop_raw = 1'b1;
    sw_if.btn_clear_raw      = 1'b1;
    step_n(3);
    chk_all("reset_hold", 2'b00, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    step_n(5);                                   // E4
    chk_all("rst_rel_E4", 2'b00, 1'b0, 1'b0, 1'b0);
    step();                                      // E5: clear wins over start
    chk_all("rst_rel_E5", 2'b00, 1'b0, 1'b0, 1'b1);
    step();                                      // E6
    chk_all("rst_rel_E6", 2'b00, 1'b0, 1'b0, 1'b0);
    sw_if.btn_start_stop_raw = 1'b0;
    sw_if.btn_clear_raw      = 1'b0;
    step_n(10);
    chk_all("rst_released", 2'b00, 1'b0, 1'b0, 1'b0);

    // 2. Start: button high for 10 sampled edges.
    sw_if.btn_start_stop_raw = 1'b1;
    step_n(5);                                   // E4
    chk_all("start_E4", 2'b00, 1'b0, 1'b0, 1'b0);
    step();                                      // E5
    chk_all("start_E5", 2'b01, 1'b1, 1'b0, 1'b0);
    step_n(3);                                   // E8
    chk_all("start_E8", 2'b01, 1'b1, 1'b0, 1'b0);
    step();                                      // E9: first tick
    chk_all("start_E9", 2'b01, 1'b1, 1'b1, 1'b0);
    sw_if.btn_start_stop_raw = 1'b0;
    step();                                      // E10
    chk_all("start_E10", 2'b01, 1'b1, 1'b0, 1'b0);
    step_n(3);                                   // E13
    chk_all("start_E13", 2'b01, 1'b1, 1'b1, 1'b0);
    step_n(7);                                   // E20: release gave no event, div=3
    chk_all("start_E20", 2'b01, 1'b1, 1'b0, 1'b0);
    step();                                      // E21: tick, div=0
    chk_all("start_E21", 2'b01, 1'b1, 1'b1, 1'b0);

    // 3. Pause with div_cnt reaching 2 on the pause edge, then resume.
    sw_if.btn_start_stop_raw = 1'b1;             // sampled first at E22
    step_n(4);                                   // E25: tick
    chk_all("pause_E25", 2'b01, 1'b1, 1'b1, 1'b0);
    step_n(2);                                   // E27: paused, div=2
    chk_all("pause_E27", 2'b10, 1'b0, 1'b0, 1'b0);
    sw_if.btn_start_stop_raw = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      chk({"paused_tick"}, {1'b0, sw_if.tick_en}, 2'b00);
    end
    chk_all("paused_hold", 2'b10, 1'b0, 1'b0, 1'b0);
    sw_if.btn_start_stop_raw = 1'b1;             // R0
    step_n(5);                                   // R4
    chk_all("resume_R4", 2'b10, 1'b0, 1'b0, 1'b0);
    step();                                      // R5
    chk_all("resume_R5", 2'b01, 1'b1, 1'b0, 1'b0);
    step();                                      // R6
    chk_all("resume_R6", 2'b01, 1'b1, 1'b0, 1'b0);
    step();                                      // R7: div resumed from 2
    chk_all("resume_R7", 2'b01, 1'b1, 1'b1, 1'b0);
    sw_if.btn_start_stop_raw = 1'b0;

    // 5. Both buttons together while running: clear only.
    step_n(3);                                   // div back to 3; let start release settle
    chk_all("clr_pre", 2'b01, 1'b1, 1'b0, 1'b0);
    step();                                      // tick, div=0
    chk_all("clr_pre_tick", 2'b01, 1'b1, 1'b1, 1'b0);
    sw_if.btn_start_stop_raw = 1'b1;             // C0
    sw_if.btn_clear_raw      = 1'b1;
    step_n(3);                                   // C2, div=3
    chk_all("clr_C2", 2'b01, 1'b1, 1'b0, 1'b0);
    step();                                      // C3: tick
    chk_all("clr_C3", 2'b01, 1'b1, 1'b1, 1'b0);
    step();                                      // C4
    chk_all("clr_C4", 2'b01, 1'b1, 1'b0, 1'b0);
    step();                                      // C5: cleared
    chk_all("clr_C5", 2'b00, 1'b0, 1'b0, 1'b1);
    sw_if.btn_start_stop_raw = 1'b0;
    sw_if.btn_clear_raw      = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      chk_all("clr_after", 2'b00, 1'b0, 1'b0, 1'b0);
    end

    // 4. Two-cycle glitch on start/stop in IDLE is rejected.
    sw_if.btn_start_stop_raw = 1'b1;
    step_n(2);
    sw_if.btn_start_stop_raw = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      chk_all("glitch", 2'b00, 1'b0, 1'b0, 1'b0);
    end

    // Restart: first tick 4 edges after entering RUN shows div_cnt was cleared.
    sw_if.btn_start_stop_raw = 1'b1;             // S0
    step_n(5);                                   // S4
    chk_all("restart_S4", 2'b00, 1'b0, 1'b0, 1'b0);
    sw_if.btn_start_stop_raw = 1'b0;
    step();                                      // S5
    chk_all("restart_S5", 2'b01, 1'b1, 1'b0, 1'b0);
    step_n(3);                                   // S8
    chk_all("restart_S8", 2'b01, 1'b1, 1'b0, 1'b0);
    step();                                      // S9
    chk_all("restart_S9", 2'b01, 1'b1, 1'b1, 1'b0);
    step_n(3);                                   // S12: div=3
    chk_all("restart_S12", 2'b01, 1'b1, 1'b0, 1'b0);

    // 6. Short asynchronous reset between edges.
    rst_n = 1'b0;
    #2;
    chk_all("async_rst", 2'b00, 1'b0, 1'b0, 1'b0);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      chk_all("post_rst", 2'b00, 1'b0, 1'b0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Front-end control stage for the stopwatch datapath. It synchronises and debounces the two raw push-buttons (start/stop and clear) and runs an IDLE/RUN/PAUSED state machine. A clock prescaler produces the single-cycle `tick_en` pulse that drives the `en` input of the first (lowest-digit) counter in the cascade. It also produces a one-cycle `counter_clr` pulse that drives the counters' active-high reset.

Parameters:
CLK_DIV, 1000000, clock cycles per tick_en pulse (100 MHz -> 10 ms); legal range >= 2
DIV_WIDTH, 20, prescaler counter width; must satisfy 2^DIV_WIDTH > CLK_DIV-1
DEBOUNCE, 500000, consecutive stable cycles required before a button level is accepted; legal range >= 1
DB_WIDTH, 19, debounce counter width; must satisfy 2^DB_WIDTH > DEBOUNCE-1

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
btn_start_stop_raw  input  1  raw asynchronous start/stop button, active-high
btn_clear_raw  input  1  raw asynchronous clear button, active-high
tick_en  output  1  registered one-cycle pulse every CLK_DIV cycles while in RUN
counter_clr  output  1  registered one-cycle pulse on accepted clear
running  output  1  registered, 1 while state == RUN
state  output  2  registered FSM state: 00 IDLE, 01 RUN, 10 PAUSED (11 unused; decodes to IDLE)

Behaviour:
- Reset (rst_n low, asynchronous):
  - All flops clear, so tick_en=0, counter_clr=0, running=0, state=IDLE.
  - Synchroniser stages, debounced levels, the delayed debounced levels, and both counters are 0.
- Synchroniser: two flops per button (s1, s2).
- Debounce, per button:
  - If s2 == db_level, db_cnt <= 0.
  - Otherwise, if db_cnt == DEBOUNCE-1: db_level <= s2 and db_cnt <= 0.
  - Otherwise db_cnt <= db_cnt+1.
  - Any glitch shorter than DEBOUNCE cycles at s2 is ignored.
- Press detect: press = db_level & ~db_level_q, where db_level_q is a registered copy. This gives exactly one cycle per accepted press. Releases are debounced identically and produce no event.
- Latency: counting as E0 the first edge that samples the raw input high, db_level rises at E(DEBOUNCE+1), press is high in the following cycle, and the state/running/counter_clr update at E(DEBOUNCE+2).
- FSM, evaluated at each edge:
  - clear press (highest priority, from any state): state <= IDLE, counter_clr <= 1, prescaler <= 0, tick_en <= 0.
  - start_stop press: IDLE->RUN, RUN->PAUSED, PAUSED->RUN.
  - Otherwise hold state.
  - If both presses occur in the same cycle, only clear acts.
  - counter_clr is 0 in every cycle where no clear is accepted.
- Prescaler:
  - In RUN: if div_cnt == CLK_DIV-1, then div_cnt <= 0 and tick_en <= 1. Otherwise div_cnt <= div_cnt+1 and tick_en <= 0.
  - In PAUSED: div_cnt holds and tick_en <= 0, so the partial period is preserved across pause/resume.
  - In IDLE: div_cnt <= 0 and tick_en <= 0.
  - First tick after IDLE->RUN: tick_en is high in the cycle after the CLK_DIV-th edge spent in RUN, then high once every CLK_DIV cycles.
  - The RUN->PAUSED transition edge is evaluated with the old state. If div_cnt == CLK_DIV-1 on that edge, one final tick_en is still issued.
- Reset mid-operation (press in progress, mid-period, or during a counter_clr pulse) aborts everything immediately. No pulse is emitted after rst_n deasserts until a new debounced press occurs.
- The unused state encoding 11 recovers to IDLE on the next edge.

Test Plan:
All scenarios run with CLK_DIV=4 and DEBOUNCE=3.

1. Reset: hold rst_n=0 with both buttons high, then release rst_n -> tick_en=0, counter_clr=0, running=0, state=00 during reset. The first state change occurs at E5 after the first sampling edge.
2. Start: raise btn_start_stop_raw for 10 cycles -> state=01 and running=1 at E5. tick_en is high for one cycle every 4 cycles, first at E9 (4 edges after entering RUN). No second transition occurs on release.
3. Pause/resume: in RUN, press start/stop while div_cnt=2 -> state=10 and no tick_en while paused. Press again -> state=01; the first tick_en arrives 2 cycles after resume (div_cnt resumes from 2).
4. Glitch reject: pulse btn_start_stop_raw high for 2 cycles in IDLE -> state stays 00, no tick_en, no counter_clr.
5. Clear priority: raise both raw buttons on the same cycle while in RUN -> state=00 at E5, counter_clr=1 for exactly one cycle, tick_en=0 and div_cnt=0 afterwards.
6. Async reset mid-run: drop rst_n for a fraction of a cycle while in RUN with div_cnt=3 -> outputs go to 0 immediately without a clock edge. No tick_en appears after release.
